line_follower_fsm: RTL and testbench
====================================

Name: line_follower_fsm

Overview:
Parametrised line-following controller for an N-sensor reflective array driving two motor controllers (per-motor reset/direction). It replaces the fixed 3-sensor controller and adds several things that block lacks: an internal step timer, centroid-based steering for any odd sensor count, an internal crossing counter, and req/done handshakes to the turn-at-crossing and station modules. It sits between the sensor inputs and the motor, turn and station blocks.

Parameters:
NUM_SENSORS, 3, sensor count; odd, 3..9; sensor[NUM_SENSORS-1] is leftmost, sensor[0] is rightmost.
STEP_CYCLES, 2000000, clk cycles per motion step; must be >=2.
CROSS_STEPS, 11, forward steps driven to clear a crossing; must be >=1.
CROSS_THRESH, 2, crossings counted before turn_req is raised; must be >=1.
GENTLE_MAX, 1, largest |offset| steered gently; a larger |offset| steers sharply.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
sensor  in  NUM_SENSORS  0 = line (black), 1 = background
turn_done  in  1  turn module finished; sampled only in TURN_REQ
station_done  in  1  station module finished; sampled only in STATION_REQ
motor_l_reset  out  1  1 = left motor stopped
motor_l_direction  out  1  left motor direction
motor_r_reset  out  1  1 = right motor stopped
motor_r_direction  out  1  right motor direction
turn_req  out  1  level request to the turn module
station_req  out  1  level request to the station module
crossing_count  out  $clog2(CROSS_THRESH+1)  crossings counted since the last turn

Behaviour:
- Reset (reset, synchronous, active-high; clock clk) applies these values:
  - state = DECIDE, start flag = 1, step timer = 0, pass counter = 0, crossing_count = 0.
  - motor_l_reset = motor_r_reset = 1, both directions = 0, turn_req = station_req = 0.
- Reset asserted mid-operation (including during a handshake) drops the requests and stops the motors on the next edge.
- Start flag: cleared on the first clock after reset where any sensor bit = 0. It is never set again until reset.
- Outputs are decoded from registered state plus the latched action (Moore).
- Motor encoding, as l_rst/l_dir/r_rst/r_dir:
  - FWD = 0/1/0/0
  - GL (gentle left) = 1/0/0/0
  - SL (sharp left) = 0/0/0/0
  - GR (gentle right) = 0/1/1/0
  - SR (sharp right) = 0/1/0/1
  - STOP = 1/0/1/0
- Offset = (index of leftmost black) + (index of rightmost black) - (NUM_SENSORS-1), as a signed value.
  - Offset 0 gives FWD.
  - 0 < offset <= GENTLE_MAX gives GL; offset > GENTLE_MAX gives SL.
  - Negative offsets give GR/SR with the same magnitude rule.
- DECIDE (1 cycle, motors STOP). Priority order:
  1. All sensors 0 -> CROSS_PASS, pass counter = 0.
  2. All sensors 1 and start = 1 -> DRIVE with FWD.
  3. All sensors 1 and start = 0 -> STATION_REQ.
  4. Otherwise -> DRIVE with the offset action latched.
- DRIVE: outputs the latched action. The step timer counts 0..STEP_CYCLES-1; at STEP_CYCLES-1 the timer clears and state -> DECIDE. Sensors are ignored during a step.
- CROSS_PASS: outputs FWD for CROSS_STEPS consecutive steps, with no DECIDE in between. At the end of the last step -> CROSS_CHECK.
- CROSS_CHECK (1 cycle, motors STOP):
  - crossing_count increments, saturating at CROSS_THRESH.
  - If the new value = CROSS_THRESH -> TURN_REQ; else -> DECIDE.
- TURN_REQ: motors STOP, turn_req = 1.
  - Held until turn_done = 1 is sampled.
  - On that edge: crossing_count = 0, state -> DECIDE, and turn_req is low from the next cycle.
  - turn_done may be a single-cycle pulse or a level.
- STATION_REQ: station_req = 1 with the same rules, completed by station_done. crossing_count is unchanged.
- done inputs seen outside their request state are ignored. turn_done and station_done never alias.
- Step timer width is $clog2(STEP_CYCLES); it cannot overflow.
- Pass counter width is $clog2(CROSS_STEPS+1).

Optional Feature:
LF_SENSOR_SYNC_EN:
- Defined: sensor passes through a 2-flop synchronizer that resets to all-ones. All decisions, including the start-flag clear, use the synchronized value, so decisions see sensors 2 cycles late.
- Undefined: sensor is used directly, with 0 added latency.

Test Plan:
All cases use NUM_SENSORS = 3, STEP_CYCLES = 8, CROSS_STEPS = 3, CROSS_THRESH = 2, GENTLE_MAX = 1.
- Reset then sensor = 3'b101 -> after 1 DECIDE cycle, FWD (0/1/0/0) for exactly 8 cycles, then STOP for 1 cycle.
- sensor = 3'b001 -> GL (1/0/0/0); 3'b011 -> SL; 3'b100 -> GR; 3'b110 -> SR; each held 8 cycles.
- Drive sensor = 3'b000 twice, with 3'b101 between:
  - First crossing: 24 cycles FWD, then crossing_count = 1.
  - Second crossing: turn_req = 1 held until turn_done.
  - 1-cycle turn_done pulse -> turn_req = 0 and crossing_count = 0 the next cycle.
- sensor = 3'b111 straight out of reset -> FWD (start = 1). After a 3'b101 step, 3'b111 -> station_req = 1 held; station_done -> DECIDE; crossing_count is unchanged.
- Assert reset during TURN_REQ -> turn_req = 0, motors STOP, crossing_count = 0 after the edge. turn_done pulsed while in DRIVE -> no effect.
- Define LF_SENSOR_SYNC_EN, change sensor from 3'b101 to 3'b011 during DECIDE -> the SL decision uses the value from 2 cycles earlier.

Source files
------------

// File: rtl/line_follower_fsm.sv
// line_follower_fsm
//   Line-following controller for an N-sensor reflective array. It steers two
//   motors from the centroid of the black sensors, times each motion step
//   internally, drives across crossings for a fixed number of steps, and counts
//   them. It hands control to the turn module once enough crossings are seen,
//   and to the station module when all sensors read background.
//
// Optional build macro:
//   LF_SENSOR_SYNC_EN - route sensor through a 2-flop synchronizer that resets
//                       to all-ones. Every decision then sees sensors 2 cycles
//                       late. When the macro is undefined, sensor is used directly.
//
// Ports:
//   clk                clock
//   reset              synchronous, active-high reset
//   sensor             per-sensor reading, 0 = line, 1 = background; [N-1] is leftmost
//   turn_done          turn module finished (sampled only while requesting a turn)
//   station_done       station module finished (sampled only while requesting a station)
//   motor_l_reset      1 = left motor stopped
//   motor_l_direction  left motor direction
//   motor_r_reset      1 = right motor stopped
//   motor_r_direction  right motor direction
//   turn_req           level request to the turn module
//   station_req        level request to the station module
//   crossing_count     crossings counted since the last turn
module line_follower_fsm #(
  parameter int NUM_SENSORS  = 3,
  parameter int STEP_CYCLES  = 2000000,
  parameter int CROSS_STEPS  = 11,
  parameter int CROSS_THRESH = 2,
  parameter int GENTLE_MAX   = 1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_SENSORS-1:0]            sensor,
  input  logic                              turn_done,
  input  logic                              station_done,
  output logic                              motor_l_reset,
  output logic                              motor_l_direction,
  output logic                              motor_r_reset,
  output logic                              motor_r_direction,
  output logic                              turn_req,
  output logic                              station_req,
  output logic [$clog2(CROSS_THRESH+1)-1:0] crossing_count
);

  localparam int TMR_W  = $clog2(STEP_CYCLES);
  localparam int PASS_W = $clog2(CROSS_STEPS + 1);
  localparam int CNT_W  = $clog2(CROSS_THRESH + 1);

  // Motor codes packed as {l_rst, l_dir, r_rst, r_dir}
  localparam logic [3:0] MOT_FWD  = 4'b0100;
  localparam logic [3:0] MOT_GL   = 4'b1000;
  localparam logic [3:0] MOT_SL   = 4'b0000;
  localparam logic [3:0] MOT_GR   = 4'b0110;
  localparam logic [3:0] MOT_SR   = 4'b0101;
  localparam logic [3:0] MOT_STOP = 4'b1010;

  typedef enum logic [2:0] {
    DECIDE, DRIVE, CROSS_PASS, CROSS_CHECK, TURN_REQ, STATION_REQ
  } state_t;

  typedef enum logic [2:0] {
    ACT_FWD, ACT_GL, ACT_SL, ACT_GR, ACT_SR
  } action_t;

  function automatic logic [3:0] motor_code(input action_t a);
    case (a)
      ACT_GL:  return MOT_GL;
      ACT_SL:  return MOT_SL;
      ACT_GR:  return MOT_GR;
      ACT_SR:  return MOT_SR;
      default: return MOT_FWD;
    endcase
  endfunction

  logic [NUM_SENSORS-1:0] sens;

`ifdef LF_SENSOR_SYNC_EN
  logic [NUM_SENSORS-1:0] sens_meta, sens_sync;

  always_ff @(posedge clk) begin
    if (reset) begin
      sens_meta <= '1;
      sens_sync <= '1;
    end else begin
      sens_meta <= sensor;
      sens_sync <= sens_meta;
    end
  end

  assign sens = sens_sync;
`else
  assign sens = sensor;
`endif

  state_t              state, state_n;
  action_t             action, action_n, offset_action;
  logic                start;
  logic [TMR_W-1:0]    timer, timer_n;
  logic [PASS_W-1:0]   pass_cnt, pass_n;
  logic [CNT_W-1:0]    count_n;
  logic [3:0]          motors_n;
  logic                all_black, all_white, step_end;
  int                  hi_idx, lo_idx, offset;

  assign all_black = (sens == '0);
  assign all_white = (sens == '1);
  assign step_end  = (timer == TMR_W'(STEP_CYCLES - 1));

  // Centroid of the black run: positive offset means the line lies left of centre.
  always_comb begin
    hi_idx = 0;
    lo_idx = 0;
    for (int i = 0; i < NUM_SENSORS; i++)
      if (!sens[i]) hi_idx = i;
    for (int i = NUM_SENSORS - 1; i >= 0; i--)
      if (!sens[i]) lo_idx = i;
    offset = hi_idx + lo_idx - (NUM_SENSORS - 1);

    if (offset == 0)
      offset_action = ACT_FWD;
    else if (offset > 0)
      offset_action = (offset <= GENTLE_MAX) ? ACT_GL : ACT_SL;
    else
      offset_action = (-offset <= GENTLE_MAX) ? ACT_GR : ACT_SR;
  end

  always_comb begin
    state_n  = state;
    action_n = action;
    timer_n  = timer;
    pass_n   = pass_cnt;
    count_n  = crossing_count;

    case (state)
      DECIDE: begin
        timer_n = '0;
        if (all_black) begin
          state_n = CROSS_PASS;
          pass_n  = '0;
        end else if (all_white && start) begin
          state_n  = DRIVE;
          action_n = ACT_FWD;
        end else if (all_white) begin
          state_n = STATION_REQ;
        end else begin
          state_n  = DRIVE;
          action_n = offset_action;
        end
      end
      DRIVE: begin
        if (step_end) begin
          timer_n = '0;
          state_n = DECIDE;
        end else begin
          timer_n = timer + TMR_W'(1);
        end
      end
      // Steps chain back to back here; no DECIDE between them.
      CROSS_PASS: begin
        if (step_end) begin
          timer_n = '0;
          if (pass_cnt == PASS_W'(CROSS_STEPS - 1))
            state_n = CROSS_CHECK;
          else
            pass_n = pass_cnt + PASS_W'(1);
        end else begin
          timer_n = timer + TMR_W'(1);
        end
      end
      CROSS_CHECK: begin
        if (crossing_count != CNT_W'(CROSS_THRESH))
          count_n = crossing_count + CNT_W'(1);
        state_n = (count_n == CNT_W'(CROSS_THRESH)) ? TURN_REQ : DECIDE;
      end
      TURN_REQ: begin
        if (turn_done) begin
          count_n = '0;
          state_n = DECIDE;
        end
      end
      STATION_REQ: begin
        if (station_done) state_n = DECIDE;
      end
      default: state_n = DECIDE;
    endcase

    // Outputs are decoded from the state being entered so they are registered.
    motors_n = MOT_STOP;
    if (state_n == DRIVE)
      motors_n = motor_code(action_n);
    else if (state_n == CROSS_PASS)
      motors_n = MOT_FWD;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= DECIDE;
      start          <= 1'b1;
      timer          <= '0;
      pass_cnt       <= '0;
      crossing_count <= '0;
      {motor_l_reset, motor_l_direction, motor_r_reset, motor_r_direction} <= MOT_STOP;
      turn_req       <= 1'b0;
      station_req    <= 1'b0;
    end else begin
      state          <= state_n;
      timer          <= timer_n;
      pass_cnt       <= pass_n;
      crossing_count <= count_n;
      if (!all_white) start <= 1'b0;
      {motor_l_reset, motor_l_direction, motor_r_reset, motor_r_direction} <= motors_n;
      turn_req       <= (state_n == TURN_REQ);
      station_req    <= (state_n == STATION_REQ);
    end
  end

  // The latched action only matters once DRIVE is entered, which always reloads it.
  always_ff @(posedge clk) begin
    action <= action_n;
  end

endmodule

// File: tb/tb_line_follower_fsm.sv
module tb_line_follower_fsm;

  localparam int NS = 3;
  localparam int SC = 8;
  localparam int CS = 3;
  localparam int CT = 2;
  localparam int GM = 1;
  localparam int CW = $clog2(CT + 1);

  localparam logic [3:0] M_FWD  = 4'b0100;
  localparam logic [3:0] M_GL   = 4'b1000;
  localparam logic [3:0] M_SL   = 4'b0000;
  localparam logic [3:0] M_GR   = 4'b0110;
  localparam logic [3:0] M_SR   = 4'b0101;
  localparam logic [3:0] M_STOP = 4'b1010;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [NS-1:0] sensor = '1;
  logic          turn_done = 1'b0;
  logic          station_done = 1'b0;
  logic          motor_l_reset, motor_l_direction, motor_r_reset, motor_r_direction;
  logic          turn_req, station_req;
  logic [CW-1:0] crossing_count;

  int n_checks = 0;
  int n_fail   = 0;

  line_follower_fsm #(
    .NUM_SENSORS(NS), .STEP_CYCLES(SC), .CROSS_STEPS(CS),
    .CROSS_THRESH(CT), .GENTLE_MAX(GM)
  ) dut (
    .clk(clk), .reset(reset), .sensor(sensor),
    .turn_done(turn_done), .station_done(station_done),
    .motor_l_reset(motor_l_reset), .motor_l_direction(motor_l_direction),
    .motor_r_reset(motor_r_reset), .motor_r_direction(motor_r_direction),
    .turn_req(turn_req), .station_req(station_req),
    .crossing_count(crossing_count)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] motors();
    return {motor_l_reset, motor_l_direction, motor_r_reset, motor_r_direction};
  endfunction

  // ---------------- behavioural reference model ----------------
  // The robot is described as a sequence of phases: a decision instant, a
  // timed motion of some total length, a crossing tally, or a wait on a peer.
  typedef enum {PH_DECIDE, PH_MOVE, PH_CHECK, PH_TURN, PH_STATION} phase_t;

  phase_t        ph = PH_DECIDE;
  int            left = 0;
  logic [3:0]    mv = M_FWD;
  bit            after_cross = 0;
  bit            m_start = 1;
  int            m_count = 0;
  bit            m_valid = 0;
  logic [NS-1:0] hist0 = '1;
  logic [NS-1:0] hist1 = '1;

  // Steering from the black run's endpoints relative to the array centre.
  function automatic logic [3:0] steer(input logic [NS-1:0] s);
    int lo, hi, off;
    lo = -1;
    hi = -1;
    for (int i = 0; i < NS; i++)
      if (s[i] == 1'b0) begin
        if (lo < 0) lo = i;
        hi = i;
      end
    off = lo + hi - (NS - 1);
    if (off == 0) return M_FWD;
    if (off > 0)  return (off <= GM) ? M_GL : M_SL;
    return (-off <= GM) ? M_GR : M_SR;
  endfunction

  always @(posedge clk) begin : model
    logic [NS-1:0] s;
    if (reset) begin
      m_valid = 1;
      ph      = PH_DECIDE;
      m_start = 1;
      m_count = 0;
      left    = 0;
      hist0   = '1;
      hist1   = '1;
    end else begin
`ifdef LF_SENSOR_SYNC_EN
      s     = hist1;
      hist1 = hist0;
      hist0 = sensor;
`else
      s = sensor;
`endif
      case (ph)
        PH_DECIDE: begin
          if (s == '0) begin
            ph = PH_MOVE; left = CS * SC; mv = M_FWD; after_cross = 1;
          end else if (s == '1) begin
            if (m_start) begin
              ph = PH_MOVE; left = SC; mv = M_FWD; after_cross = 0;
            end else begin
              ph = PH_STATION;
            end
          end else begin
            ph = PH_MOVE; left = SC; mv = steer(s); after_cross = 0;
          end
        end
        PH_MOVE: begin
          left = left - 1;
          if (left == 0) ph = after_cross ? PH_CHECK : PH_DECIDE;
        end
        PH_CHECK: begin
          if (m_count < CT) m_count = m_count + 1;
          ph = (m_count == CT) ? PH_TURN : PH_DECIDE;
        end
        PH_TURN: begin
          if (turn_done) begin
            m_count = 0;
            ph = PH_DECIDE;
          end
        end
        PH_STATION: begin
          if (station_done) ph = PH_DECIDE;
        end
        default: ph = PH_DECIDE;
      endcase
      if (s != '1) m_start = 0;
    end
  end

  always @(negedge clk) begin : compare
    logic [3:0] e_m;
    logic       e_t, e_s;
    if (m_valid) begin
      e_m = (ph == PH_MOVE) ? mv : M_STOP;
      e_t = (ph == PH_TURN);
      e_s = (ph == PH_STATION);
      n_checks++;
      if (motors() !== e_m || turn_req !== e_t || station_req !== e_s ||
          crossing_count !== CW'(m_count)) begin
        n_fail++;
        $display("FAIL model t=%0t: got motors=%b turn_req=%b station_req=%b count=%0d, required motors=%b turn_req=%b station_req=%b count=%0d",
                 $time, motors(), turn_req, station_req, crossing_count, e_m, e_t, e_s, m_count);
      end
    end
  end

  // ---------------- literal expectations ----------------
  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Called at a negedge while the DUT is in its decision cycle; ends likewise.
  task automatic step_lit(input string name, input logic [NS-1:0] s, input logic [3:0] m);
    sensor = s;
    @(negedge clk);
    lit({name, " first"}, 32'(motors()), 32'(m));
    repeat (SC - 1) @(negedge clk);
    lit({name, " last"}, 32'(motors()), 32'(m));
    @(negedge clk);
    lit({name, " decide"}, 32'(motors()), 32'(M_STOP));
  endtask

  // Crossing of CS steps; ends at the negedge after the crossing tally.
  task automatic cross_lit(input string name);
    sensor = '0;
    @(negedge clk);
    lit({name, " fwd first"}, 32'(motors()), 32'(M_FWD));
    repeat (CS * SC - 1) @(negedge clk);
    lit({name, " fwd last"}, 32'(motors()), 32'(M_FWD));
    sensor = 3'b101;
    @(negedge clk);
    lit({name, " check stop"}, 32'(motors()), 32'(M_STOP));
    @(negedge clk);
  endtask

  initial begin
    int r;
    reset  = 1'b1;
    sensor = 3'b101;
    repeat (3) @(negedge clk);
    lit("reset motors", 32'(motors()), 32'(M_STOP));
    lit("reset turn_req", 32'(turn_req), 32'd0);
    lit("reset station_req", 32'(station_req), 32'd0);
    lit("reset count", 32'(crossing_count), 32'd0);

`ifndef LF_SENSOR_SYNC_EN
    reset = 1'b0;
    step_lit("fwd", 3'b101, M_FWD);
    step_lit("gentle left", 3'b001, M_GL);
    step_lit("sharp left", 3'b011, M_SL);
    step_lit("gentle right", 3'b100, M_GR);
    step_lit("sharp right", 3'b110, M_SR);

    cross_lit("cross1");
    lit("cross1 count", 32'(crossing_count), 32'd1);
    lit("cross1 no turn", 32'(turn_req), 32'd0);

    // Station handshake with start already cleared; count must survive it.
    sensor = '1;
    @(negedge clk);
    lit("station req", 32'(station_req), 32'd1);
    repeat (3) @(negedge clk);
    lit("station held", 32'(station_req), 32'd1);
    lit("station motors", 32'(motors()), 32'(M_STOP));
    station_done = 1'b1;
    @(negedge clk);
    station_done = 1'b0;
    lit("station released", 32'(station_req), 32'd0);
    lit("station count kept", 32'(crossing_count), 32'd1);
    step_lit("after station", 3'b101, M_FWD);

    cross_lit("cross2");
    lit("turn req", 32'(turn_req), 32'd1);
    lit("turn count", 32'(crossing_count), 32'd2);
    repeat (3) @(negedge clk);
    lit("turn held", 32'(turn_req), 32'd1);
    turn_done = 1'b1;
    @(negedge clk);
    turn_done = 1'b0;
    lit("turn released", 32'(turn_req), 32'd0);
    lit("turn count clear", 32'(crossing_count), 32'd0);

    // turn_done while driving is ignored.
    sensor = 3'b101;
    @(negedge clk);
    turn_done = 1'b1;
    @(negedge clk);
    turn_done = 1'b0;
    lit("stray done motors", 32'(motors()), 32'(M_FWD));
    repeat (SC - 2) @(negedge clk);
    @(negedge clk);
    lit("stray done decide", 32'(motors()), 32'(M_STOP));
    lit("stray done no req", 32'(turn_req), 32'd0);

    // Reset while requesting a turn.
    cross_lit("cross3");
    cross_lit("cross4");
    lit("pre-reset turn req", 32'(turn_req), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    lit("mid reset turn_req", 32'(turn_req), 32'd0);
    lit("mid reset motors", 32'(motors()), 32'(M_STOP));
    lit("mid reset count", 32'(crossing_count), 32'd0);
    sensor = '1;
    reset  = 1'b0;
    step_lit("start fwd", 3'b111, M_FWD);
`endif

    // Randomised phase, checked every cycle by the model.
    for (int c = 0; c < 4000; c++) begin
      r = $urandom_range(0, 99);
      if (r < 12)      sensor = '0;
      else if (r < 24) sensor = '1;
      else             sensor = NS'($urandom);
      turn_done    = ($urandom_range(0, 9) == 0);
      station_done = ($urandom_range(0, 9) == 0);
      reset        = ($urandom_range(0, 499) == 0);
      @(negedge clk);
    end
    reset = 1'b0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
